mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_starve_ctr.sv | 28 ++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int DEF_LAT        = 2;
    localparam int DEF_STARVE_LIM = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating fetch-starvation counter with force-fetch flag
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic force_fetch
);

    localparam logic [3:0] LIMIT_VAL = 4'(LIMIT);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc && (count != LIMIT_VAL)) begin
            count <= count + 4'd1;
        end
    end

    assign force_fetch = (count == LIMIT_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT        = DEF_LAT,
    parameter int STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_adr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [31:0] m_adr,
    output logic [31:0] m_wdata,
    output logic        m_read,
    output logic        m_write,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        owner
);

    localparam logic [2:0] LAST_CYC = 3'(LAT - 1);

    arb_state_t state;
    logic [2:0] acc_cnt;
    logic       acc_we;
    logic       force_fetch;
    logic       grant_d;
    logic       grant_i;

    // Data normally wins; a starved fetch takes the port once the limit is hit.
    assign grant_d = (state == ST_IDLE) && d_req && !(i_req && force_fetch);
    assign grant_i = (state == ST_IDLE) && i_req && !grant_d;

    arb_starve_ctr #(
        .LIMIT(STARVE_LIM)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .inc        (grant_d && i_req),
        .clr        (grant_i),
        .force_fetch(force_fetch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            acc_cnt <= 3'd0;
            acc_we  <= 1'b0;
            owner   <= OWN_I;
            busy    <= 1'b0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= 32'd0;
            d_rdata <= 32'd0;
            m_adr   <= 32'd0;
            m_wdata <= 32'd0;
            m_read  <= 1'b0;
            m_write <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_d || grant_i) begin
                        state   <= ST_ACCESS;
                        busy    <= 1'b1;
                        acc_cnt <= 3'd0;
                        owner   <= grant_d ? OWN_D : OWN_I;
                        acc_we  <= grant_d && d_we;
                        m_adr   <= grant_d ? d_adr : i_adr;
                        m_wdata <= grant_d ? d_wdata : 32'd0;
                        m_read  <= !(grant_d && d_we);
                        m_write <= grant_d && d_we;
                    end
                end
                ST_ACCESS: begin
                    // Writes strobe once; the slot still lasts LAT cycles.
                    m_write <= 1'b0;
                    if (acc_cnt == LAST_CYC) begin
                        state  <= ST_DONE;
                        m_read <= 1'b0;
                        if (!acc_we) begin
                            if (owner == OWN_D) d_rdata <= m_rdata;
                            else                i_rdata <= m_rdata;
                        end
                        if (owner == OWN_D) d_ack <= 1'b1;
                        else                i_ack <= 1'b1;
                    end else begin
                        acc_cnt <= acc_cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    m_read  <= 1'b0;
                    m_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
